alu_issue_queue: RTL and testbench

//  Upstream issue/capture stage for the 8-bit combinational ALU. Buffers operand/opcode

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_fifo.sv | 50 +++++
 rtl/alu_issue_queue.sv | 123 ++++++++++++
 tb/tb_alu_issue_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/capture shell: opcodes, FSM states
// and the packed command width ({a, b, op}).
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_SHL = 3'b011;
   localparam logic [2:0] OP_SHR = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam int CMD_W = 19;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full/empty are distinguishable and level is a plain pointer difference.
// There is no push/pop bypass: a pop frees its slot for the next cycle only.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] din,
   output logic [CMD_W-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr[AW-1:0]];

   // pointer update; the wrap bit rolls naturally at DEPTH
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // storage write; contents are only read back after being written
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue/capture shell around the combinational 8-bit ALU.
// Optional build macro: ALU_ZERO_FLAG_EN adds the res_zero output.
//
//  state | meaning
//  IDLE  | no command in flight; pop head when FIFO non-empty
//  EXEC  | ALU regs loaded, ALU settling; capture result at end of cycle
//  HOLD  | result presented on res_*; wait for res_ready
module alu_issue_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic [15:0] alu_out,
   input  logic        alu_cb,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_out,
   output logic        res_cb,
   output logic [AW:0] level
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic        res_zero
`endif
);

   state_t           state_q;
   state_t           state_d;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [CMD_W-1:0] head;

   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({cmd_a, cmd_b, cmd_op}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state and pop decision; HOLD pops directly for back-to-back issue
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: state_d = HOLD;
         HOLD: begin
            if (res_ready) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ALU operand registers and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         res_valid <= 1'b0;
         res_out   <= '0;
         res_cb    <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
         res_zero  <= 1'b0;
`endif
      end else begin
         if (pop) {alu_a, alu_b, alu_op} <= head;
         if (state_q == EXEC) begin
            res_out   <= alu_out;
            // the ALU leaves cb stale for non-arithmetic ops
            res_cb    <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) ? alu_cb : 1'b0;
            res_valid <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
            res_zero  <= (alu_out == 16'h0);
`endif
         end else if ((state_q == HOLD) && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU on the alu_* bus.
// Expected results are hand-computed constants queued alongside each push.
module tb_alu_issue_queue;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_out;
   logic        alu_cb;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_out;
   logic        res_cb;
   logic [AW:0] level;
`ifdef ALU_ZERO_FLAG_EN
   logic        res_zero;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [16:0] exp_q [$];
   int          stamp [8];

   alu_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_op    (cmd_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .alu_cb    (alu_cb),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_out   (res_out),
      .res_cb    (res_cb),
      .level     (level)
`ifdef ALU_ZERO_FLAG_EN
      ,
      .res_zero  (res_zero)
`endif
   );

   always #5 clk = ~clk;

   // behavioural ALU; cb is driven high for non-arithmetic ops on purpose
   always_comb begin
      logic [8:0] s;
      s       = 9'h0;
      alu_out = 16'h0;
      alu_cb  = 1'b1;
      case (alu_op)
         OP_ADD: begin
            s       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_out = {8'h0, s[7:0]};
            alu_cb  = s[8];
         end
         OP_SUB: begin
            s       = {1'b0, alu_a} - {1'b0, alu_b};
            alu_out = {8'h0, s[7:0]};
            alu_cb  = s[8];
         end
         OP_MUL:  alu_out = {8'h0, alu_a} * {8'h0, alu_b};
         OP_SHL:  alu_out = {8'h0, alu_a << alu_b[2:0]};
         OP_SHR:  alu_out = {8'h0, alu_a >> alu_b[2:0]};
         OP_AND:  alu_out = {8'h0, alu_a & alu_b};
         OP_OR:   alu_out = {8'h0, alu_a | alu_b};
         default: alu_out = {8'h0, alu_a ^ alu_b};
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // offer a command until accepted; returns just after the accepting edge
   task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [15:0] eo, input logic ec);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      while (!done && n < 50) begin
         if (cmd_ready === 1'b1) done = 1'b1;
         tick();
         n++;
      end
      cmd_valid = 1'b0;
      if (done) exp_q.push_back({ec, eo});
      else      chk("push_timeout", 32'(0), 32'(1));
   endtask

   // with res_ready high, wait for n results; returns while the last one is visible
   task automatic collect(input int n, input int budget);
      int          got;
      int          cyc;
      logic [16:0] e;
      got = 0;
      cyc = 0;
      while (got < n && cyc < budget) begin
         if (res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk("res_out", 32'(res_out), 32'(e[15:0]));
               chk("res_cb",  32'(res_cb),  32'(e[16]));
            end
            stamp[got] = cyc;
            got++;
         end
         if (got < n) begin
            tick();
            cyc++;
         end
      end
      if (got < n) chk("collect_timeout", 32'(got), 32'(n));
   endtask

   initial begin
      int          vcnt;
      logic [2:0]  lvl_exp [5];
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      res_ready = 1'b0;
      lvl_exp   = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

      // 1: reset, then idle
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_res_valid", 32'(res_valid), 32'(0));
      chk("rst_res_out",   32'(res_out),   32'(0));
      chk("rst_res_cb",    32'(res_cb),    32'(0));
      chk("rst_alu_a",     32'(alu_a),     32'(0));
      chk("rst_alu_b",     32'(alu_b),     32'(0));
      chk("rst_alu_op",    32'(alu_op),    32'(0));
      chk("rst_level",     32'(level),     32'(0));
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
`ifdef ALU_ZERO_FLAG_EN
      chk("rst_res_zero",  32'(res_zero),  32'(0));
`endif
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (res_valid !== 1'b0) vcnt++;
         tick();
      end
      chk("idle_no_valid", 32'(vcnt), 32'(0));

      // 2: ADD 200+100, latency
      res_ready = 1'b1;
      push_cmd(8'd200, 8'd100, OP_ADD, 16'd44, 1'b1);
      chk("t2_level_after_push", 32'(level), 32'(1));
      chk("t2_valid_n",          32'(res_valid), 32'(0));
      tick();
      chk("t2_alu_a",            32'(alu_a), 32'(200));
      chk("t2_alu_b",            32'(alu_b), 32'(100));
      chk("t2_alu_op",           32'(alu_op), 32'(OP_ADD));
      chk("t2_valid_n1",         32'(res_valid), 32'(0));
      tick();
      collect(1, 1);
      tick();
      chk("t2_valid_cleared",    32'(res_valid), 32'(0));

      // 3: fill with res_ready low, overflow attempt, then drain
      res_ready = 1'b0;
      push_cmd(8'd10,  8'd20,  OP_ADD, 16'd30,   1'b0);
      chk("t3_level0", 32'(level), 32'(lvl_exp[0]));
      push_cmd(8'd15,  8'd17,  OP_MUL, 16'd255,  1'b0);
      chk("t3_level1", 32'(level), 32'(lvl_exp[1]));
      push_cmd(8'h0F,  8'hF0,  OP_OR,  16'h00FF, 1'b0);
      chk("t3_level2", 32'(level), 32'(lvl_exp[2]));
      push_cmd(8'hFF,  8'h0F,  OP_XOR, 16'h00F0, 1'b0);
      chk("t3_level3", 32'(level), 32'(lvl_exp[3]));
      push_cmd(8'd20,  8'd5,   OP_SUB, 16'd15,   1'b0);
      chk("t3_level4", 32'(level), 32'(lvl_exp[4]));
      chk("t3_full_ready", 32'(cmd_ready), 32'(0));
      cmd_valid = 1'b1;
      cmd_a     = 8'd1;
      cmd_b     = 8'd1;
      cmd_op    = OP_ADD;
      tick();
      cmd_valid = 1'b0;
      chk("t3_level_after_reject", 32'(level), 32'(DEPTH));
      chk("t3_hold_valid",         32'(res_valid), 32'(1));
      tick();
      tick();
      chk("t3_hold_out",           32'(res_out), 32'(30));
      chk("t3_hold_cb",            32'(res_cb),  32'(0));
      res_ready = 1'b1;
      collect(5, 40);
      tick();
      chk("t3_drained_level",      32'(level), 32'(0));

      // 4: SUB with borrow, then AND (cb gated to 0)
      push_cmd(8'd5,  8'd9,  OP_SUB, 16'h00FC, 1'b1);
      push_cmd(8'hF0, 8'h3C, OP_AND, 16'h0030, 1'b0);
      collect(2, 20);
      tick();

      // 5: back-to-back issue, then reset mid-stream
      res_ready = 1'b0;
      push_cmd(8'd1,  8'd1,  OP_ADD, 16'd2,    1'b0);
      push_cmd(8'd3,  8'd4,  OP_OR,  16'd7,    1'b0);
      push_cmd(8'hAA, 8'h55, OP_XOR, 16'h00FF, 1'b0);
      tick();
      res_ready = 1'b1;
      collect(2, 20);
      chk("t5_gap", 32'(stamp[1] - stamp[0]), 32'(2));
      chk("t5_level_mid", 32'(level), 32'(1));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      chk("t5_rst_valid", 32'(res_valid), 32'(0));
      chk("t5_rst_level", 32'(level),     32'(0));
      chk("t5_rst_ready", 32'(cmd_ready), 32'(1));
      chk("t5_rst_alu_a", 32'(alu_a),     32'(0));
      chk("t5_rst_out",   32'(res_out),   32'(0));
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (res_valid !== 1'b0) vcnt++;
      end
      chk("t5_no_valid_after_rst", 32'(vcnt), 32'(0));

`ifdef ALU_ZERO_FLAG_EN
      // 6: zero flag
      push_cmd(8'h5A, 8'h5A, OP_XOR, 16'h0000, 1'b0);
      collect(1, 10);
      chk("t6_zero_set", 32'(res_zero), 32'(1));
      tick();
      push_cmd(8'd1, 8'd0, OP_OR, 16'h0001, 1'b0);
      collect(1, 10);
      chk("t6_zero_clr", 32'(res_zero), 32'(0));
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
